// File: rtl/tile_flip_pkg.sv
// Shared definitions for the Tile Flip game sequencer: board geometry,
// state encoding and the tile value extractor.
package tile_flip_pkg;

    localparam int NUM_TILES  = 16;
    localparam int VAL_W      = 3;
    localparam int NUM_LEVELS = 4;
    localparam int IDX_W      = $clog2(NUM_TILES);
    localparam int LVL_W      = $clog2(NUM_LEVELS);
    localparam int SETUP_W    = NUM_TILES * VAL_W;
    localparam int MOVES_W    = 8;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_LOAD        = 3'd1;
    localparam logic [2:0] ST_WAIT_FIRST  = 3'd2;
    localparam logic [2:0] ST_WAIT_SECOND = 3'd3;
    localparam logic [2:0] ST_COMPARE     = 3'd4;
    localparam logic [2:0] ST_SHOW        = 3'd5;
    localparam logic [2:0] ST_LEVEL_CHK   = 3'd6;
    localparam logic [2:0] ST_GAME_DONE   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE        = ST_IDLE,
        S_LOAD        = ST_LOAD,
        S_WAIT_FIRST  = ST_WAIT_FIRST,
        S_WAIT_SECOND = ST_WAIT_SECOND,
        S_COMPARE     = ST_COMPARE,
        S_SHOW        = ST_SHOW,
        S_LEVEL_CHK   = ST_LEVEL_CHK,
        S_GAME_DONE   = ST_GAME_DONE
    } state_t;

    // Value of tile idx within the packed board word.
    function automatic logic [VAL_W-1:0] tile_val(input logic [SETUP_W-1:0] setup,
                                                  input logic [IDX_W-1:0]   idx);
        int base;
        base = VAL_W * int'(idx);
        return setup[base +: VAL_W];
    endfunction

endpackage

// File: rtl/tile_game_ctrl_show_timer.sv
// Count-down timer that keeps a mismatched pair face-up. Loaded with
// MAX_COUNT, it counts down while enabled; expire marks the final cycle
// of the hold window, so the window lasts exactly MAX_COUNT enabled cycles.
module show_timer #(
    parameter  int MAX_COUNT = 8,
    localparam int CNT_W     = $clog2(MAX_COUNT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count;

    // Load the hold length, then decrement once per enabled cycle down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(MAX_COUNT);
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/tile_game_ctrl.sv
// Tile Flip game sequencer: selects the level, takes player selections in
// pairs, compares tile values, tracks matched tiles and move count, and
// steps through the levels until the game is complete.
module tile_game_ctrl
    import tile_flip_pkg::*;
#(
    parameter int SHOW_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sel_valid,
    input  logic [IDX_W-1:0]     sel_idx,
    input  logic [SETUP_W-1:0]   tile_setup,
    output logic [LVL_W-1:0]     level,
    output logic                 sel_ready,
    output logic [NUM_TILES-1:0] revealed,
    output logic [NUM_TILES-1:0] matched,
    output logic [MOVES_W-1:0]   moves,
    output logic                 level_done,
    output logic                 game_done
);

    localparam logic [LVL_W-1:0] LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);

    state_t           state;
    logic             load_wait;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] second_idx;
    logic             vals_equal;
    logic             accept;
    logic             all_matched;
    logic             timer_load;
    logic             timer_en;
    logic             timer_expire;

    assign accept      = sel_valid && sel_ready;
    assign all_matched = &matched;
    assign vals_equal  = (tile_val(tile_setup, first_idx) == tile_val(tile_setup, second_idx));
    assign timer_load  = (state == S_COMPARE) && !vals_equal;
    assign timer_en    = (state == S_SHOW);

    show_timer #(
        .MAX_COUNT (SHOW_CYCLES)
    ) u_show_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .en     (timer_en),
        .expire (timer_expire)
    );

    // Game sequencer: state, board masks, move counter and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            level      <= '0;
            sel_ready  <= 1'b0;
            revealed   <= '0;
            matched    <= '0;
            moves      <= '0;
            level_done <= 1'b0;
            game_done  <= 1'b0;
            load_wait  <= 1'b0;
            first_idx  <= '0;
            second_idx <= '0;
        end else begin
            level_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        level     <= '0;
                        load_wait <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Two cycles so the registered tile_setup follows the new level.
                    matched  <= '0;
                    revealed <= '0;
                    moves    <= '0;
                    if (load_wait) begin
                        load_wait <= 1'b0;
                        sel_ready <= 1'b1;
                        state     <= S_WAIT_FIRST;
                    end else begin
                        load_wait <= 1'b1;
                    end
                end
                S_WAIT_FIRST: begin
                    if (accept && !matched[sel_idx]) begin
                        revealed[sel_idx] <= 1'b1;
                        first_idx         <= sel_idx;
                        state             <= S_WAIT_SECOND;
                    end
                end
                S_WAIT_SECOND: begin
                    if (accept && !matched[sel_idx] && (sel_idx != first_idx)) begin
                        revealed[sel_idx] <= 1'b1;
                        second_idx        <= sel_idx;
                        sel_ready         <= 1'b0;
                        state             <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (moves != '1) begin
                        moves <= moves + MOVES_W'(1);
                    end
                    if (vals_equal) begin
                        matched  <= matched | revealed;
                        revealed <= '0;
                        state    <= S_LEVEL_CHK;
                    end else begin
                        state <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (timer_expire) begin
                        revealed  <= '0;
                        sel_ready <= 1'b1;
                        state     <= S_WAIT_FIRST;
                    end
                end
                S_LEVEL_CHK: begin
                    if (!all_matched) begin
                        sel_ready <= 1'b1;
                        state     <= S_WAIT_FIRST;
                    end else begin
                        level_done <= 1'b1;
                        if (level == LAST_LEVEL) begin
                            game_done <= 1'b1;
                            state     <= S_GAME_DONE;
                        end else begin
                            level     <= level + LVL_W'(1);
                            load_wait <= 1'b0;
                            state     <= S_LOAD;
                        end
                    end
                end
                S_GAME_DONE: begin
                    if (start) begin
                        game_done <= 1'b0;
                        level     <= '0;
                        load_wait <= 1'b0;
                        state     <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_game_ctrl.sv
// Testbench for tile_game_ctrl with a behavioural stand-in for level_select.
module tb_tile_game_ctrl;

    localparam int SHOW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        sel_valid = 1'b0;
    logic [3:0]  sel_idx = 4'd0;
    logic [47:0] tile_setup = '0;
    logic [1:0]  level;
    logic        sel_ready;
    logic [15:0] revealed;
    logic [15:0] matched;
    logic [7:0]  moves;
    logic        level_done;
    logic        game_done;

    int n_pass = 0;
    int n_total = 0;
    int ld_total = 0;

    tile_game_ctrl #(.SHOW_CYCLES(SHOW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sel_valid  (sel_valid),
        .sel_idx    (sel_idx),
        .tile_setup (tile_setup),
        .level      (level),
        .sel_ready  (sel_ready),
        .revealed   (revealed),
        .matched    (matched),
        .moves      (moves),
        .level_done (level_done),
        .game_done  (game_done)
    );

    always #5 clk = ~clk;

    // Board values per level: tile i and tile i+8 always share a value.
    function automatic logic [2:0] ref_val(input int lvl, input int i);
        return 3'(((7 - (i % 8)) + lvl) % 8);
    endfunction

    function automatic logic [47:0] setup_of(input int lvl);
        logic [47:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) s[3*i +: 3] = ref_val(lvl, i);
        return s;
    endfunction

    // level_select stand-in: registered board lookup, one cycle behind level.
    always @(posedge clk) tile_setup <= setup_of(int'(level));

    // Count level_done pulses.
    always @(negedge clk) if (level_done) ld_total <= ld_total + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input int i);
        sel_valid = 1'b1;
        sel_idx = 4'(i);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rev"}, 32'(revealed), 32'h0);
        check({name, "_mat"}, 32'(matched), 32'h0);
        check({name, "_moves"}, 32'(moves), 32'h0);
        check({name, "_ctl"}, 32'({level, sel_ready, level_done, game_done}), 32'h0);
    endtask

    typedef struct {
        logic        vld;
        int          idx;
        int          settle;
        logic [15:0] rev;
        logic [15:0] mat;
        logic [7:0]  mv;
        logic        rdy;
    } vec_t;

    vec_t vt[10];

    int          n, ld0, m_ld, m_busy, m_first, m_level, m_moves, ix;
    logic [15:0] m_matched, m_revealed;
    bit          m_play, m_done, v, st, start_acc, sel_acc;

    initial begin
        vt[0] = '{1'b1, 0,  0, 16'h0001, 16'h0000, 8'd0, 1'b1};
        vt[1] = '{1'b1, 8,  2, 16'h0000, 16'h0101, 8'd1, 1'b1};
        vt[2] = '{1'b1, 8,  0, 16'h0000, 16'h0101, 8'd1, 1'b1};
        vt[3] = '{1'b1, 3,  0, 16'h0008, 16'h0101, 8'd1, 1'b1};
        vt[4] = '{1'b1, 3,  0, 16'h0008, 16'h0101, 8'd1, 1'b1};
        vt[5] = '{1'b1, 0,  0, 16'h0008, 16'h0101, 8'd1, 1'b1};
        vt[6] = '{1'b1, 11, 2, 16'h0000, 16'h0909, 8'd2, 1'b1};
        vt[7] = '{1'b0, 5,  0, 16'h0000, 16'h0909, 8'd2, 1'b1};
        vt[8] = '{1'b1, 1,  0, 16'h0002, 16'h0909, 8'd2, 1'b1};
        vt[9] = '{1'b1, 2,  9, 16'h0000, 16'h0909, 8'd3, 1'b1};

        // Reset state
        reset = 1'b1;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        reset = 1'b0;

        // Start and LOAD
        start_game();
        check("load_ready", 32'(sel_ready), 32'h1);
        check("load_level", 32'(level), 32'h0);
        check("load_mat", 32'(matched), 32'h0);
        check("load_moves", 32'(moves), 32'h0);

        // Selection vectors on level 0
        for (int k = 0; k < 10; k++) begin
            sel_valid = vt[k].vld;
            sel_idx = 4'(vt[k].idx);
            tick();
            sel_valid = 1'b0;
            repeat (vt[k].settle) tick();
            check($sformatf("vec%0d_rev", k), 32'(revealed), 32'(vt[k].rev));
            check($sformatf("vec%0d_mat", k), 32'(matched), 32'(vt[k].mat));
            check($sformatf("vec%0d_moves", k), 32'(moves), 32'(vt[k].mv));
            check($sformatf("vec%0d_ready", k), 32'(sel_ready), 32'(vt[k].rdy));
        end

        // Mismatch hold window, with selections during SHOW ignored
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start_game();
        sel(0);
        sel(1);
        check("cmp_rev", 32'(revealed), 32'h3);
        check("cmp_ready", 32'(sel_ready), 32'h0);
        tick();
        n = 0;
        sel_valid = 1'b1;
        sel_idx = 4'd5;
        for (int k = 0; k < 40 && !sel_ready; k++) begin
            if (revealed == 16'h0003) n++;
            tick();
        end
        sel_valid = 1'b0;
        check("show_cycles", 32'(n), 32'd8);
        check("show_rev_clr", 32'(revealed), 32'h0);
        check("show_moves", 32'(moves), 32'd1);
        check("show_ready", 32'(sel_ready), 32'h1);

        // Full game through all four levels
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start_game();
        ld0 = ld_total;
        for (int lv = 0; lv < 4; lv++) begin
            for (int i = 0; i < 8; i++) begin
                sel(i);
                sel(i + 8);
                tick();
                tick();
                if (i == 6) check($sformatf("lv%0d_mat7", lv), 32'(matched), 32'h7f7f);
            end
            check($sformatf("lv%0d_done", lv), 32'(level_done), 32'h1);
            if (lv < 3) begin
                check($sformatf("lv%0d_next", lv), 32'(level), 32'(lv + 1));
                tick();
                check($sformatf("lv%0d_pulse", lv), 32'(level_done), 32'h0);
                tick();
                check($sformatf("lv%0d_ready", lv), 32'(sel_ready), 32'h1);
                check($sformatf("lv%0d_clr", lv), 32'(matched), 32'h0);
                check($sformatf("lv%0d_moves", lv), 32'(moves), 32'h0);
            end else begin
                check("gd_flag", 32'(game_done), 32'h1);
                check("gd_mat", 32'(matched), 32'hffff);
                check("gd_level", 32'(level), 32'h3);
                tick();
                check("gd_pulse", 32'(level_done), 32'h0);
                check("gd_hold", 32'(game_done), 32'h1);
            end
        end
        tick();
        check("gd_pulses", 32'(ld_total - ld0), 32'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_level", 32'(level), 32'h0);
        check("restart_gd", 32'(game_done), 32'h0);
        tick();
        tick();
        check("restart_ready", 32'(sel_ready), 32'h1);
        check("restart_mat", 32'(matched), 32'h0);

        // Reset during SHOW
        sel(0);
        sel(1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_all_zero("rst_show");
        tick();
        reset = 1'b0;
        sel(2);
        check("idle_ignore_ready", 32'(sel_ready), 32'h0);
        check("idle_ignore_rev", 32'(revealed), 32'h0);
        // start and select together from IDLE: the select is dropped
        start = 1'b1;
        sel_valid = 1'b1;
        sel_idx = 4'd4;
        tick();
        start = 1'b0;
        sel_valid = 1'b0;
        check("startsel_level", 32'(level), 32'h0);
        tick();
        tick();
        check("startsel_ready", 32'(sel_ready), 32'h1);
        check("startsel_rev", 32'(revealed), 32'h0);

        // Reset during WAIT_SECOND
        sel(0);
        reset = 1'b1;
        #1;
        check_all_zero("rst_wait2");
        tick();
        reset = 1'b0;

        // Move counter saturation
        start_game();
        for (int p = 1; p <= 300; p++) begin
            sel(0);
            sel(1);
            repeat (9) tick();
            if (p == 254) check("moves_254", 32'(moves), 32'd254);
            if (p == 255) check("moves_255", 32'(moves), 32'd255);
        end
        check("moves_sat", 32'(moves), 32'd255);
        check("sat_ready", 32'(sel_ready), 32'h1);

        // Randomized play against the reference model
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ld0 = ld_total;
        m_ld = 0;
        m_play = 0;
        m_done = 0;
        m_busy = 0;
        m_first = -1;
        m_level = 0;
        m_moves = 0;
        m_matched = '0;
        m_revealed = '0;
        for (int c = 0; c < 6000; c++) begin
            v = ($urandom_range(3) != 0);
            if (m_first >= 0 && $urandom_range(1) == 1) ix = m_first ^ 8;
            else ix = int'($urandom_range(15));
            if (!m_play && m_busy == 0) st = ($urandom_range(3) == 0);
            else st = ($urandom_range(63) == 0);
            sel_valid = v;
            sel_idx = 4'(ix);
            start = st;
            start_acc = st && !m_play && m_busy == 0;
            sel_acc = v && m_play && m_busy == 0;
            tick();
            sel_valid = 1'b0;
            start = 1'b0;
            if (m_busy > 0) m_busy--;
            if (start_acc) begin
                m_level = 0;
                m_matched = '0;
                m_revealed = '0;
                m_moves = 0;
                m_first = -1;
                m_play = 1;
                m_done = 0;
                m_busy = 2;
            end else if (sel_acc && !m_matched[ix]) begin
                if (m_first < 0) begin
                    m_first = ix;
                    m_revealed[ix] = 1'b1;
                end else if (ix != m_first) begin
                    if (m_moves < 255) m_moves++;
                    if (ref_val(m_level, m_first) == ref_val(m_level, ix)) begin
                        m_matched[ix] = 1'b1;
                        m_matched[m_first] = 1'b1;
                        if (m_matched == 16'hffff) begin
                            m_ld++;
                            if (m_level == 3) begin
                                m_play = 0;
                                m_done = 1;
                                m_busy = 2;
                            end else begin
                                m_level++;
                                m_matched = '0;
                                m_moves = 0;
                                m_busy = 4;
                            end
                        end else begin
                            m_busy = 2;
                        end
                    end else begin
                        m_busy = 1 + SHOW;
                    end
                    m_revealed = '0;
                    m_first = -1;
                end
            end
            check("rnd_ready", 32'(sel_ready), 32'(m_play && m_busy == 0));
            if (m_busy == 0 && m_play) begin
                check("rnd_rev", 32'(revealed), 32'(m_revealed));
                check("rnd_mat", 32'(matched), 32'(m_matched));
                check("rnd_moves", 32'(moves), 32'(m_moves));
                check("rnd_level", 32'(level), 32'(m_level));
            end
            if (m_busy == 0 && m_done) begin
                check("rnd_gd", 32'(game_done), 32'h1);
                check("rnd_gd_mat", 32'(matched), 32'hffff);
            end
        end
        repeat (6) tick();
        check("rnd_level_done_count", 32'(ld_total - ld0), 32'(m_ld));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
